// File: rtl/gamepad_reader_if.sv
// Bundles the poll request, pad wires and decoded button outputs of the pad reader.
// Pure wiring; no storage and no added latency.
// No backpressure: i_poll is a fire-and-forget pulse, outputs are level/pulse only.
interface gamepad_reader_if #(
  parameter int NUM_BUTTONS = 8
);
  logic                   i_poll;
  logic                   i_pad_data;
  logic                   o_pad_latch;
  logic                   o_pad_clk;
  logic [NUM_BUTTONS-1:0] o_buttons;
  logic                   o_up;
  logic                   o_down;
  logic                   o_left;
  logic                   o_right;
  logic                   o_pause;
  logic                   o_restart;
  logic                   o_valid;
  logic                   o_busy;
  logic                   o_disconnected;

  // Reader side: consumes the poll request and pad data, drives everything else.
  modport master (
    input  i_poll, i_pad_data,
    output o_pad_latch, o_pad_clk, o_buttons, o_up, o_down, o_left, o_right,
           o_pause, o_restart, o_valid, o_busy, o_disconnected
  );

  // Game/pad side: issues polls, supplies pad data, observes the results.
  modport slave (
    output i_poll, i_pad_data,
    input  o_pad_latch, o_pad_clk, o_buttons, o_up, o_down, o_left, o_right,
           o_pause, o_restart, o_valid, o_busy, o_disconnected
  );
endinterface

// File: rtl/gamepad_reader.sv
// Serial NES/SNES pad initiator: latches the pad, clocks out its bits, publishes active-high buttons.
// Latency: poll in cycle 0 -> latch in cycle 1 -> o_valid in cycle 1+CLK_DIV*(2*NUM_BUTTONS+1).
// No backpressure: polls arriving while busy are dropped, results are simply overwritten.
module gamepad_reader #(
  parameter int CLK_DIV     = 150,
  parameter int NUM_BUTTONS = 8
) (
  input  logic            clk,
  input  logic            rst,
  gamepad_reader_if.master bus
);

  localparam int CW = $clog2(2 * CLK_DIV);
  localparam int IW = $clog2(NUM_BUTTONS);

  localparam logic [CW-1:0] LATCH_LAST = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_BUTTONS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NUM_BUTTONS-1:0] shift_q, shift_d;
  logic [NUM_BUTTONS-1:0] buttons_q, buttons_d;
  logic                   disc_q, disc_d;
  logic                   valid_q;
  logic                   latch_q;
  logic                   pad_clk_q;
  logic                   sync1_q, sync2_q;

  // Two-flop synchronizer for the asynchronous pad data; idles high like an open line.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.i_pad_data;
      sync2_q <= sync1_q;
    end
  end

  // Next-state logic: phase timing, bit sampling and result formation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    buttons_d = buttons_q;
    disc_d    = disc_q;

    case (state_q)
      S_IDLE: begin
        if (bus.i_poll) begin
          state_d = S_LATCH;
          cnt_d   = '0;
        end
      end
      S_LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HIGH: begin
        if (cnt_q == HALF_LAST) begin
          // Sample at the end of the high phase, as far from the pad's data change as possible.
          cnt_d          = '0;
          shift_d[idx_q] = sync2_q;
          state_d        = (idx_q == IDX_LAST) ? S_DONE : S_LOW;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LOW: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = idx_q + IW'(1);
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Results are loaded on entry to DONE so they appear together with o_valid.
    if (state_q == S_HIGH && state_d == S_DONE) begin
      if (&shift_d) begin
        buttons_d = '0;
        disc_d    = 1'b1;
      end else begin
        buttons_d = ~shift_d;
        disc_d    = 1'b0;
      end
    end
  end

  // State and output registers; pad strobes decode from next state so the pins are flop-driven.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      buttons_q <= '0;
      disc_q    <= 1'b0;
      valid_q   <= 1'b0;
      latch_q   <= 1'b0;
      pad_clk_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      buttons_q <= buttons_d;
      disc_q    <= disc_d;
      valid_q   <= (state_d == S_DONE);
      latch_q   <= (state_d == S_LATCH);
      pad_clk_q <= (state_d != S_LOW);
    end
  end

  assign bus.o_pad_latch    = latch_q;
  assign bus.o_pad_clk      = pad_clk_q;
  assign bus.o_buttons      = buttons_q;
  assign bus.o_up           = buttons_q[4];
  assign bus.o_down         = buttons_q[5];
  assign bus.o_left         = buttons_q[6];
  assign bus.o_right        = buttons_q[7];
  assign bus.o_pause        = buttons_q[3];
  assign bus.o_restart      = buttons_q[2];
  assign bus.o_valid        = valid_q;
  assign bus.o_busy         = (state_q != S_IDLE);
  assign bus.o_disconnected = disc_q;

endmodule

// File: tb/tb_gamepad_reader.sv
// Bench for gamepad_reader: one NES-width and one SNES-width instance, each with a pad model.
// Expected pin timing and results come from a cycle-offset model of the poll.
// Directed polls cover basic reads, disconnect, ignored polls, mid-poll reset and data noise.
module tb_gamepad_reader;

  localparam int CD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gamepad_reader_if #(.NUM_BUTTONS(8))  bus8();
  gamepad_reader_if #(.NUM_BUTTONS(12)) bus12();

  gamepad_reader #(.CLK_DIV(CD), .NUM_BUTTONS(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  gamepad_reader #(.CLK_DIV(CD), .NUM_BUTTONS(12)) dut12 (.clk(clk), .rst(rst), .bus(bus12));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Pad models: active-high pressed vectors, connection flags, shift registers, noise injection.
  logic [11:0] press [2];
  logic        conn  [2];
  logic        nz    [2];
  logic        nbit  [2];
  logic        noise_en = 1'b0;
  logic [11:0] sr8, sr12;

  // Reference model state per DUT.
  int          start [2] = '{-1, -1};
  logic [11:0] exp_btn [2] = '{12'h0, 12'h0};
  logic        exp_disc [2] = '{1'b0, 1'b0};
  logic [11:0] pend_btn [2];
  logic        pend_disc [2];
  int          vcnt [2] = '{0, 0};
  int          vcyc [2] = '{-1, -1};
  int          lowcnt [2] = '{0, 0};
  logic        prev_clk [2] = '{1'b1, 1'b1};

  always @(posedge clk) cyc++;

  // A real pad: parallel load while latched, shift on each pad clock rise, ones beyond the end.
  always @(posedge bus8.o_pad_clk or posedge bus8.o_pad_latch)
    if (bus8.o_pad_latch) sr8 = ~press[0];
    else                  sr8 = {1'b1, sr8[11:1]};

  always @(posedge bus12.o_pad_clk or posedge bus12.o_pad_latch)
    if (bus12.o_pad_latch) sr12 = ~press[1];
    else                   sr12 = {1'b1, sr12[11:1]};

  assign bus8.i_pad_data  = nz[0] ? nbit[0] : (conn[0] ? sr8[0]  : 1'b1);
  assign bus12.i_pad_data = nz[1] ? nbit[1] : (conn[1] ? sr12[0] : 1'b1);

  // Random data on the NES line wherever no sample can see it (not within 3 cycles of a high-phase end).
  always @(posedge clk) begin
    int t, p;
    #1;
    nz[0]   = 1'b0;
    nbit[0] = 1'($urandom_range(0, 1));
    if (noise_en && start[0] >= 0) begin
      t = cyc - start[0];
      p = t - 1 - 2 * CD;
      if (t >= 1 && t < 1 + CD * 17 &&
          (p < 0 || (p % (2 * CD)) < CD - 3 || (p % (2 * CD)) >= CD))
        nz[0] = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Model: outputs as a function of cycles elapsed since the accepted poll.
  task automatic check_dut(input int d, input int n, input logic latch, input logic pclk,
                           input logic busy, input logic valid, input logic disc,
                           input logic [11:0] btn, input logic [5:0] dirs, input logic poll);
    int L, t, p;
    logic [11:0] mask, raw;
    logic e_latch, e_clk, e_busy, e_valid;
    L = 1 + CD * (2 * n + 1);
    t = (start[d] >= 0) ? cyc - start[d] : -1;
    if (t == L) begin
      exp_btn[d]  = pend_btn[d];
      exp_disc[d] = pend_disc[d];
    end
    e_latch = (t >= 1 && t <= 2 * CD);
    p       = t - 1 - 2 * CD;
    e_clk   = !(p >= 0 && p < CD * (2 * n - 1) && ((p / CD) % 2 == 1));
    e_busy  = (t >= 1 && t <= L);
    e_valid = (t == L);
    chk($sformatf("d%0d_latch", d), 32'(latch), 32'(e_latch));
    chk($sformatf("d%0d_pad_clk", d), 32'(pclk), 32'(e_clk));
    chk($sformatf("d%0d_busy", d), 32'(busy), 32'(e_busy));
    chk($sformatf("d%0d_valid", d), 32'(valid), 32'(e_valid));
    chk($sformatf("d%0d_buttons", d), 32'(btn), 32'(exp_btn[d]));
    chk($sformatf("d%0d_disc", d), 32'(disc), 32'(exp_disc[d]));
    chk($sformatf("d%0d_dirs", d), 32'(dirs),
        32'({exp_btn[d][4], exp_btn[d][5], exp_btn[d][6], exp_btn[d][7], exp_btn[d][3], exp_btn[d][2]}));
    if (valid) begin
      vcnt[d]++;
      vcyc[d] = t;
    end
    if (prev_clk[d] && !pclk) lowcnt[d]++;
    prev_clk[d] = pclk;
    if (rst) begin
      start[d]    = -1;
      exp_btn[d]  = '0;
      exp_disc[d] = 1'b0;
    end else if (poll && (t < 0 || t > L)) begin
      start[d] = cyc;
      mask     = 12'((13'h1 << n) - 13'h1);
      raw      = conn[d] ? (~press[d] & mask) : mask;
      if (raw == mask) begin
        pend_btn[d]  = '0;
        pend_disc[d] = 1'b1;
      end else begin
        pend_btn[d]  = ~raw & mask;
        pend_disc[d] = 1'b0;
      end
    end
  endtask

  // Single compare process, sampling on the falling edge.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      check_dut(0, 8, bus8.o_pad_latch, bus8.o_pad_clk, bus8.o_busy, bus8.o_valid,
                bus8.o_disconnected, {4'h0, bus8.o_buttons},
                {bus8.o_up, bus8.o_down, bus8.o_left, bus8.o_right, bus8.o_pause, bus8.o_restart},
                bus8.i_poll);
      check_dut(1, 12, bus12.o_pad_latch, bus12.o_pad_clk, bus12.o_busy, bus12.o_valid,
                bus12.o_disconnected, bus12.o_buttons,
                {bus12.o_up, bus12.o_down, bus12.o_left, bus12.o_right, bus12.o_pause, bus12.o_restart},
                bus12.i_poll);
    end
  end

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic poll8();
    bus8.i_poll = 1'b1;
    step(1);
    bus8.i_poll = 1'b0;
  endtask

  task automatic poll12();
    bus12.i_poll = 1'b1;
    step(1);
    bus12.i_poll = 1'b0;
  endtask

  initial begin
    logic [7:0] vec6 [3];
    vec6 = '{8'h5A, 8'hA5, 8'h3C};
    bus8.i_poll  = 1'b0;
    bus12.i_poll = 1'b0;
    press = '{12'h0, 12'h0};
    conn  = '{1'b1, 1'b1};
    rst   = 1'b1;
    step(3);
    rst = 1'b0;
    step(2);

    // Up + Start pressed: serial 1,1,1,0,0,1,1,1.
    press[0]  = 12'h018;
    vcnt[0]   = 0;
    lowcnt[0] = 0;
    poll8();
    step(75);
    chk("t1_valid_count", 32'(vcnt[0]), 32'd1);
    chk("t1_valid_cycle", 32'(vcyc[0]), 32'd69);
    chk("t1_low_pulses", 32'(lowcnt[0]), 32'd7);
    chk("t1_buttons", 32'(bus8.o_buttons), 32'h18);
    chk("t1_up", 32'(bus8.o_up), 32'd1);
    chk("t1_pause", 32'(bus8.o_pause), 32'd1);
    chk("t1_disc", 32'(bus8.o_disconnected), 32'd0);

    // No pad: line floats high.
    conn[0] = 1'b0;
    poll8();
    step(75);
    chk("t2_buttons", 32'(bus8.o_buttons), 32'h0);
    chk("t2_disc", 32'(bus8.o_disconnected), 32'd1);
    conn[0]  = 1'b1;
    press[0] = 12'h040;
    poll8();
    step(75);
    chk("t2_left", 32'(bus8.o_left), 32'd1);
    chk("t2_disc_clear", 32'(bus8.o_disconnected), 32'd0);

    // Extra polls while busy are dropped; poll right after DONE is accepted.
    press[0] = 12'h081;
    vcnt[0]  = 0;
    poll8();          // rel 0
    step(9);
    poll8();          // rel 10
    step(57);
    poll8();          // rel 68
    step(1);
    poll8();          // rel 70
    chk("t3_latch_at_71", 32'(bus8.o_pad_latch), 32'd1);
    chk("t3_one_valid", 32'(vcnt[0]), 32'd1);
    chk("t3_first_valid_cycle", 32'(vcyc[0]), 32'd69);
    step(75);
    chk("t3_second_valid", 32'(vcnt[0]), 32'd2);
    chk("t3_buttons", 32'(bus8.o_buttons), 32'h81);

    // Reset at cycle 30 of a poll.
    press[0] = 12'h0FF;
    vcnt[0]  = 0;
    poll8();
    step(29);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t4_latch", 32'(bus8.o_pad_latch), 32'd0);
    chk("t4_pad_clk", 32'(bus8.o_pad_clk), 32'd1);
    chk("t4_busy", 32'(bus8.o_busy), 32'd0);
    chk("t4_buttons", 32'(bus8.o_buttons), 32'h0);
    step(80);
    chk("t4_no_valid", 32'(vcnt[0]), 32'd0);
    press[0] = 12'h024;
    poll8();
    step(75);
    chk("t4_fresh_valid", 32'(vcnt[0]), 32'd1);
    chk("t4_fresh_buttons", 32'(bus8.o_buttons), 32'h24);

    // SNES: R (bit 11) and Select (bit 2).
    press[1]  = 12'h804;
    vcnt[1]   = 0;
    lowcnt[1] = 0;
    poll12();
    step(105);
    chk("t5_valid_cycle", 32'(vcyc[1]), 32'd101);
    chk("t5_low_pulses", 32'(lowcnt[1]), 32'd11);
    chk("t5_buttons", 32'(bus12.o_buttons), 32'h804);
    chk("t5_restart", 32'(bus12.o_restart), 32'd1);

    // Noise away from sample points, three consecutive polls.
    noise_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      press[0] = {4'h0, vec6[i]};
      poll8();
      step(70);
      chk($sformatf("t6_poll%0d", i), 32'(bus8.o_buttons), 32'(vec6[i]));
    end
    noise_en = 1'b0;
    step(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gamepad_reader.md
Name: gamepad_reader

Overview:
- Initiator side of the serial NES/SNES controller link.
- Generates the latch and clock strobes to the pad and shifts in its active-low button bits.
- Presents the result as registered, active-high button levels: up/down/left/right/pause/restart, plus the raw vector.
- Sits in front of the game's input ports and is typically triggered once per frame from vsync.

Parameters:
- CLK_DIV, 150: system cycles per pad-clock half period; also the latch pulse is 2*CLK_DIV. Legal range ≥4.
- NUM_BUTTONS, 8: bits read per poll. 8 selects NES, 12 selects SNES; no other values are legal.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- i_poll  in  1  poll request; one-cycle pulse, e.g. at vsync.
- i_pad_data  in  1  serial data from the pad; asynchronous; low = pressed; floats high when no pad is attached.
- o_pad_latch  out  1  latch strobe to the pad.
- o_pad_clk  out  1  shift clock to the pad; idles high.
- o_buttons  out  NUM_BUTTONS  active-high pressed vector; bit i is the i-th bit read.
- o_up / o_down / o_left / o_right  out  1 each  o_buttons[4] / [5] / [6] / [7].
- o_pause  out  1  o_buttons[3] (Start).
- o_restart  out  1  o_buttons[2] (Select).
- o_valid  out  1  one-cycle pulse when the outputs are updated.
- o_busy  out  1  high in every state except IDLE.
- o_disconnected  out  1  last poll read all ones.

Behaviour:
- Reset values: o_pad_latch=0, o_pad_clk=1, o_buttons=0, all derived button outputs 0, o_valid=0, o_busy=0, o_disconnected=0. State=IDLE, bit index=0, counter=0, synchronizer flops=1.
- Reset mid-poll aborts the poll. IDLE takes effect on the next cycle with the above values, and no o_valid is issued.
- i_pad_data passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- States: IDLE, LATCH, HIGH, LOW, DONE.
- IDLE:
  - o_pad_latch=0, o_pad_clk=1.
  - i_poll=1 moves to LATCH and clears the counter.
  - i_poll in any other state, including DONE, is ignored and not queued.
- LATCH:
  - o_pad_latch=1 for exactly 2*CLK_DIV cycles.
  - Then go to HIGH with bit index 0.
- HIGH:
  - o_pad_clk=1 for CLK_DIV cycles.
  - On the last cycle, shift[idx] <= synchronized data.
  - If idx==NUM_BUTTONS-1, go to DONE; else go to LOW.
- LOW:
  - o_pad_clk=0 for CLK_DIV cycles.
  - Then idx++ and go to HIGH. The rising edge of o_pad_clk makes the pad advance to the next bit.
  - Exactly NUM_BUTTONS-1 low pulses occur per poll.
- DONE, one cycle:
  - If shift is all ones: o_buttons <= 0, o_disconnected <= 1.
  - Otherwise: o_buttons <= ~shift, o_disconnected <= 0.
  - o_valid=1 in the cycle the new values first appear. Return to IDLE.
- Latency: with i_poll high in cycle 0, o_pad_latch rises in cycle 1, and o_valid plus the new outputs appear in cycle 1+CLK_DIV*(2*NUM_BUTTONS+1).
- Outputs hold their values between polls. o_pad_latch and o_pad_clk are registered and glitch-free. The counter is sized to $clog2(2*CLK_DIV).
- Back-to-back polling: an i_poll in the cycle immediately after DONE (state IDLE) is accepted.
- Synchronizer lag of 2 cycles is less than CLK_DIV. A bit driven by the pad after a rising edge is therefore stable at its sample point.

Test Plan:
1. CLK_DIV=4, NUM_BUTTONS=8, pad model returns Up and Start pressed (serial 1,1,1,0,0,1,1,1). Pulse i_poll at cycle 0.
   -> o_pad_latch high cycles 1–8; 7 low pulses on o_pad_clk; o_valid at cycle 69 only; o_buttons=8'h18, o_up=1, o_pause=1, others 0, o_disconnected=0.
2. Data held constantly high (no pad).
   -> o_buttons=0 and o_disconnected=1 after o_valid. A following poll with a pad pressing Left gives o_left=1 and o_disconnected=0.
3. i_poll pulsed again at cycles 10 and 68 of a poll in progress.
   -> exactly one o_valid at cycle 69; o_busy high cycles 1–69. An i_poll at cycle 70 starts a new poll with latch at cycle 71.
4. rst asserted at cycle 30 of a poll.
   -> next cycle: latch=0, pad_clk=1, o_busy=0, o_buttons=0; no o_valid for that poll. A fresh poll then completes normally.
5. NUM_BUTTONS=12, CLK_DIV=4, pad presses R (last bit) and Select.
   -> 11 clock pulses; o_valid at cycle 101; o_buttons=12'h804; o_restart=1.
6. Toggle i_pad_data away from its sample points, held stable ≥3 cycles before each HIGH-phase end.
   -> sampled vector equals the intended vector on every one of 3 consecutive polls.
